div_sequencer: RTL and testbench

// - Sequences the multi-cycle unsigned divider and its HiLo write in the EX stage of the pipelined MIPS core.
// - Detects DIVU in EX, loads the divider and issues one step per cycle for ITER cycles.
// - Holds the pipeline stalled until the result is ready, then pulses the HiLo write enable.
// - Sits beside the ALU control decode; drives the divider and HiLo enables and the hazard unit's stall input.

---
 rtl/ctrl_pkg.sv | 25 ++
 rtl/div_iter_counter.sv | 30 +++
 rtl/div_sequencer.sv | 118 +++++++++++
 tb/tb_div_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared EX-stage control definitions: R-type funct codes, divider sequencer
// state encoding and the default divider iteration count.
package ctrl_pkg;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam int unsigned DIV_ITER  = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Divider step counter: synchronous clear has priority over enable; tc flags
// the final iteration (count == ITER-1).
module div_iter_counter #(
  parameter int unsigned ITER  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == CNT_W'(ITER - 1));

endmodule

// File: rtl/div_sequencer.sv
// EX-stage DIVU sequencer: loads the divider, issues ITER steps while stalling
// the pipeline, then pulses the HiLo write (or flags a zero divisor).
module div_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned ITER       = DIV_ITER,
  parameter int unsigned CNT_W      = DIV_CNT_W,
  parameter logic [5:0]  FUNCT_DIVU = F_DIVU
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       funct_ex,
  input  logic             valid_ex,
  input  logic             divisor_zero,
  input  logic             flush,
  input  logic             ext_hold,
  output logic             stall,
  output logic             div_load,
  output logic             div_step,
  output logic             hilo_we,
  output logic             dz_flag,
  output logic             busy,
  output logic [CNT_W-1:0] step_idx
);

  div_state_t       r_state, w_next;
  logic             r_dz, w_dz_next;
  logic             w_go, w_clr, w_en, w_tc;
  logic [CNT_W-1:0] w_count;

  div_iter_counter #(
    .ITER  (ITER),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_en),
    .count (w_count),
    .tc    (w_tc)
  );

  assign w_go = valid_ex & (funct_ex == FUNCT_DIVU) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dz    <= w_dz_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_dz_next = r_dz;
    w_clr     = 1'b0;
    w_en      = 1'b0;
    stall     = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    hilo_we   = 1'b0;
    dz_flag   = 1'b0;
    step_idx  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          stall = 1'b1;
          if (divisor_zero) begin
            w_next    = ST_WRITE;
            w_dz_next = 1'b1;
          end else begin
            div_load  = 1'b1;
            w_next    = ST_RUN;
            w_clr     = 1'b1;
            w_dz_next = 1'b0;
          end
        end
      end
      ST_RUN: begin
        stall    = 1'b1;
        div_step = 1'b1;
        step_idx = w_count;
        w_en     = 1'b1;
        if (w_tc) begin
          w_next = ST_WRITE;
          w_clr  = 1'b1;
        end
      end
      ST_WRITE: begin
        // A flush in the write cycle aborts the commit as well as the FSM.
        hilo_we   = ~r_dz & ~flush;
        dz_flag   = r_dz & ~flush;
        w_dz_next = 1'b0;
        w_next    = ext_hold ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!ext_hold) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    if (flush) begin
      w_next    = ST_IDLE;
      w_clr     = 1'b1;
      w_dz_next = 1'b0;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: a job-timeline model predicts each
// cycle's outputs, a negedge monitor pops and compares.
module tb_div_sequencer;
  import ctrl_pkg::*;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       funct_ex = F_ADD;
  logic             valid_ex = 1'b0;
  logic             divisor_zero = 1'b0;
  logic             flush = 1'b0;
  logic             ext_hold = 1'b0;
  logic             stall, div_load, div_step, hilo_we, dz_flag, busy;
  logic [CNT_W-1:0] step_idx;

  typedef struct packed {
    logic             stall;
    logic             load;
    logic             step;
    logic             we;
    logic             dz;
    logic             busy;
    logic [CNT_W-1:0] idx;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          we_times[$];
  int          exp_we_cnt = 0;

  // Model: a job accepted at age 0 commits at age ITER+1 (or 1 for zero divisor).
  bit m_active = 0;
  bit m_zero   = 0;
  bit m_hold   = 0;
  int m_age    = 0;

  div_sequencer #(
    .ITER       (ITER),
    .CNT_W      (CNT_W),
    .FUNCT_DIVU (F_DIVU)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .funct_ex     (funct_ex),
    .valid_ex     (valid_ex),
    .divisor_zero (divisor_zero),
    .flush        (flush),
    .ext_hold     (ext_hold),
    .stall        (stall),
    .div_load     (div_load),
    .div_step     (div_step),
    .hilo_we      (hilo_we),
    .dz_flag      (dz_flag),
    .busy         (busy),
    .step_idx     (step_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {stall, div_load, div_step, hilo_we, dz_flag, busy, step_idx};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cyc=%0d actual(stall,load,step,we,dz,busy,idx)=%b required=%b",
                    cyc, a, e);
      if (hilo_we === 1'b1) we_times.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [5:0] f, input logic v, input logic dz,
                      input logic fl, input logic hd);
    exp_t e;
    bit   go;
    int   wage;
    funct_ex = f; valid_ex = v; divisor_zero = dz; flush = fl; ext_hold = hd;
    e    = '0;
    go   = v && (f == F_DIVU) && !fl;
    wage = m_zero ? 1 : ITER + 1;
    if (m_hold) begin
      e.busy = 1'b1;
    end else if (m_active) begin
      e.busy = 1'b1;
      if (m_age == wage) begin
        e.we = !m_zero && !fl;
        e.dz = m_zero && !fl;
      end else begin
        e.stall = 1'b1;
        e.step  = 1'b1;
        e.idx   = CNT_W'(m_age - 1);
      end
    end else if (go) begin
      e.stall = 1'b1;
      e.load  = !dz;
    end
    q.push_back(e);
    if (e.we) exp_we_cnt++;

    if (fl) begin
      m_active = 0; m_hold = 0;
    end else if (m_hold) begin
      m_hold = hd;
    end else if (m_active) begin
      if (m_age == wage) begin
        m_active = 0;
        m_hold   = hd;
      end else begin
        m_age++;
      end
    end else if (go) begin
      m_active = 1; m_age = 1; m_zero = dz;
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle();
    logic [CNT_W+5:0] a;
    rst = 1'b1; valid_ex = 1'b0; flush = 1'b0; ext_hold = 1'b0; funct_ex = F_ADD;
    #1;
    a = {stall, div_load, div_step, hilo_we, dz_flag, busy, step_idx};
    n_checks++;
    if (a === '0) n_pass++;
    else $display("FAIL reset_immediate actual=%b required=0", a);
    q.push_back('0);
    m_active = 0; m_hold = 0; m_zero = 0; m_age = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] rand_funct();
    logic [5:0] tbl [0:5];
    tbl[0] = F_DIVU; tbl[1] = F_DIVU; tbl[2] = F_ADD;
    tbl[3] = F_MFHI; tbl[4] = F_MFLO; tbl[5] = F_SLT;
    return tbl[$urandom_range(0, 5)];
  endfunction

  initial begin
    int w0;
    @(posedge clk); #1;
    rst_cycle(); rst_cycle();
    rst = 1'b0;

    // Normal divide then an ADD
    for (int i = 0; i <= ITER + 1; i++) step(F_DIVU, 1, 0, 0, 0);
    step(F_ADD, 1, 0, 0, 0);

    // Zero divisor
    step(F_DIVU, 1, 1, 0, 0);
    step(F_DIVU, 1, 1, 0, 0);
    step(F_ADD, 1, 0, 0, 0);

    // Flush at step_idx 10, then an unstalled ADD
    for (int i = 0; i <= 10; i++) step(F_DIVU, 1, 0, 0, 0);
    step(F_DIVU, 1, 0, 1, 0);
    step(F_ADD, 1, 0, 0, 0);
    step(F_ADD, 1, 0, 0, 0);

    // Back-to-back DIVU with two HOLD cycles after the first write
    w0 = we_times.size();
    for (int i = 0; i <= ITER; i++) step(F_DIVU, 1, 0, 0, 0);
    step(F_DIVU, 1, 0, 0, 1);
    step(F_DIVU, 1, 0, 0, 1);
    step(F_DIVU, 1, 0, 0, 0);
    for (int i = 0; i <= ITER + 1; i++) step(F_DIVU, 1, 0, 0, 0);
    step(F_ADD, 1, 0, 0, 0);
    n_checks++;
    if (we_times.size() == w0 + 2 && (we_times[w0+1] - we_times[w0]) >= ITER + 2) n_pass++;
    else $display("FAIL b2b_spacing actual_pulses=%0d required=2 (spacing >= %0d)",
                  we_times.size() - w0, ITER + 2);

    // Bubbles and non-divide functs
    step(F_DIVU, 0, 0, 0, 0);
    step(F_MFHI, 1, 0, 0, 0);
    step(F_ADD, 1, 1, 0, 1);
    step(F_MFLO, 1, 0, 0, 0);

    // Reset held three cycles mid-RUN
    for (int i = 0; i < 8; i++) step(F_DIVU, 1, 0, 0, 0);
    rst_cycle(); rst_cycle(); rst_cycle();
    rst = 1'b0;
    step(F_ADD, 1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(rand_funct(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0));
    end
    step(F_ADD, 0, 0, 0, 0);
    @(negedge clk); #1;

    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain actual=%0d required=0", q.size());
    n_checks++;
    if (we_times.size() == exp_we_cnt) n_pass++;
    else $display("FAIL hilo_we_count actual=%0d required=%0d", we_times.size(), exp_we_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
